// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets one of NUM_REQ requesters
// write a burst of up to MAX_BURST words into a shared FIFO.
// Optional feature: define FIFO_WR_ARB_STATS_EN to add the 16-bit wr_count
// output that counts every FIFO write cycle.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      wr_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      full,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         data_in,
  output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]               wr_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [IDX_W-1:0]   last_owner_r;
  logic [3:0]         burst_cnt_r;

  logic [IDX_W:0]     pick_s;
  logic               owner_req_s;
  logic               wr_en_s;
  logic [3:0]         cnt_inc_s;

  // Round-robin pick: bit IDX_W flags a hit, low bits give the index.
  // Scanning from the farthest candidate down leaves the nearest one after
  // 'last' as the final assignment, so the just-served owner ranks lowest.
  function automatic logic [IDX_W:0] pick_next(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] res;
    int idx;
    res = {(IDX_W + 1){1'b0}};
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (r[idx]) begin
        res = {1'b1, IDX_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration candidate and write qualification from the registered grant.
  always_comb begin
    pick_s      = pick_next(req, last_owner_r);
    owner_req_s = |(req & gnt_r);
    wr_en_s     = owner_req_s & ~full;
    cnt_inc_s   = burst_cnt_r + 4'd1;
  end

  // Arbiter FSM: grant in IDLE, count writes in BURST, exit on drop or limit.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gnt_r        <= {NUM_REQ{1'b0}};
      burst_cnt_r  <= 4'd0;
      last_owner_r <= LAST_RST;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_s[IDX_W]) begin
            state_r      <= ST_BURST;
            gnt_r        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s[IDX_W-1:0];
            last_owner_r <= pick_s[IDX_W-1:0];
            burst_cnt_r  <= 4'd0;
          end
        end
        ST_BURST: begin
          if (!owner_req_s) begin
            state_r <= ST_IDLE;
            gnt_r   <= {NUM_REQ{1'b0}};
          end else if (wr_en_s) begin
            burst_cnt_r <= cnt_inc_s;
            if (cnt_inc_s == MAX_BURST_C) begin
              state_r <= ST_IDLE;
              gnt_r   <= {NUM_REQ{1'b0}};
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  // FIFO-side outputs; data and ack are forced to zero when nothing is written.
  always_comb begin
    gnt   = gnt_r;
    busy  = (state_r == ST_BURST);
    wr_en = wr_en_s;
    if (wr_en_s) begin
      ack     = gnt_r;
      data_in = req_data[last_owner_r*DATA_W +: DATA_W];
    end else begin
      ack     = {NUM_REQ{1'b0}};
      data_in = {DATA_W{1'b0}};
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] wr_count_r;

  // Total write-cycle counter, wraps naturally from 16'hFFFF to 0.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_count_r <= 16'd0;
    end else if (wr_en_s) begin
      wr_count_r <= wr_count_r + 16'd1;
    end
  end

  assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with constant
// expectations plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            wr_clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            full;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            wr_en;
  logic [DW-1:0]   data_in;
  logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]     wr_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  bit          m_busy;
  int          m_owner;
  int          m_cnt;
  int          m_last;
  logic [15:0] m_wr_count;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .wr_clk   (wr_clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .gnt      (gnt),
    .ack      (ack),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .busy     (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .wr_count (wr_count)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic exp_wr_en();
    if (!m_busy) return 1'b0;
    return req[m_owner] && !full;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    if (!exp_wr_en()) return '0;
    return req_data[m_owner*DW +: DW];
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic tick();
    bit          n_busy;
    int          n_owner, n_cnt, n_last;
    logic [15:0] n_wc;
    logic        we;
    we = exp_wr_en();
    n_busy = m_busy; n_owner = m_owner; n_cnt = m_cnt; n_last = m_last;
    n_wc = m_wr_count + (we ? 16'd1 : 16'd0);
    if (rst) begin
      n_busy = 0; n_cnt = 0; n_last = N - 1; n_wc = 16'd0;
    end else if (!m_busy) begin
      for (int k = N; k >= 1; k--) begin
        if (req[(m_last + k) % N]) begin
          n_busy = 1; n_owner = (m_last + k) % N;
        end
      end
      if (n_busy) begin
        n_last = n_owner; n_cnt = 0;
      end
    end else if (!req[m_owner]) begin
      n_busy = 0;
    end else if (we) begin
      n_cnt = m_cnt + 1;
      if (n_cnt == MB) n_busy = 0;
    end
    @(posedge wr_clk);
    m_busy = n_busy; m_owner = n_owner; m_cnt = n_cnt; m_last = n_last;
    m_wr_count = n_wc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; full = 1'b0; req_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; full = 1'b0; req_data = 32'hA5A5A5A5;
    tick();
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || wr_en !== 1'b0 || ack !== 4'b0000 ||
        data_in !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: gnt=%b wr_en=%b ack=%b data=%h busy=%b required all zero",
               gnt, wr_en, ack, data_in, busy);
    end
    rst = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_single();
    int nwr;
    int wcyc[$];
    logic [DW-1:0] got[$];
    int exp_cyc[5] = '{0, 1, 2, 3, 5};
    do_reset();
    tick();
    req = 4'b0001; req_data[7:0] = 8'd3;
    #1;
    tests_run++;
    if (gnt !== 4'b0000) begin
      tests_failed++; $display("FAIL single_latency: gnt=%b required 0000", gnt);
    end
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b0001) begin
      tests_failed++; $display("FAIL single_grant: gnt=%b required 0001", gnt);
    end
    nwr = 0;
    for (int c = 0; c < 40 && nwr < 5; c++) begin
      req_data[7:0] = 8'(3 + nwr);
      #1;
      if (wr_en === 1'b1) begin
        got.push_back(data_in); wcyc.push_back(c);
        tests_run++;
        if (ack !== 4'b0001) begin
          tests_failed++; $display("FAIL single_ack: ack=%b required 0001", ack);
        end
        nwr++;
      end
      tick();
    end
    req = '0;
    tests_run++;
    if (got.size() != 5) begin
      tests_failed++; $display("FAIL single_count: writes=%0d required 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (got[i] !== 8'(3 + i) || wcyc[i] != exp_cyc[i]) begin
          tests_failed++;
          $display("FAIL single_write%0d: data=%0d cycle=%0d required data=%0d cycle=%0d",
                   i, got[i], wcyc[i], 3 + i, exp_cyc[i]);
        end
      end
    end
    tick(); tick();
  endtask

  task automatic test_round_robin();
    int k;
    do_reset();
    req = 4'b1111; req_data = 32'h44332211;
    tick();
    k = 0;
    for (int c = 0; c < 40 && k < 20; c++) begin
      #1;
      if (wr_en === 1'b1) begin
        tests_run++;
        if (onehot_idx(ack) != (k / 4) % 4 || c != k + k / 4 || gnt !== ack) begin
          tests_failed++;
          $display("FAIL rr_write%0d: owner=%0d cycle=%0d required owner=%0d cycle=%0d",
                   k, onehot_idx(ack), c, (k / 4) % 4, k + k / 4);
        end
        k++;
      end
      tick();
    end
    tests_run++;
    if (k != 20) begin
      tests_failed++; $display("FAIL rr_count: writes=%0d required 20", k);
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_full_stall();
    int n;
    do_reset();
    req = 4'b0100; req_data = 32'h00550000;
    tick();
    tick();
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (wr_en !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0100 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: wr_en=%b ack=%b gnt=%b busy=%b required 0 0000 0100 1",
                 c, wr_en, ack, gnt, busy);
      end
      tick();
    end
    full = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (gnt === 4'b0000) break;
      if (wr_en === 1'b1) n++;
      tick();
    end
    tests_run++;
    if (n != 3) begin
      tests_failed++; $display("FAIL stall_resume: writes=%0d required 3", n);
    end
    req = '0;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b1010;
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b0010) begin
      tests_failed++; $display("FAIL drop_grant: gnt=%b required 0010", gnt);
    end
    tick(); tick();
    req = 4'b1000;
    #1;
    tests_run++;
    if (wr_en !== 1'b0) begin
      tests_failed++; $display("FAIL drop_nowrite: wr_en=%b required 0", wr_en);
    end
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL drop_idle: gnt=%b busy=%b required 0000 0", gnt, busy);
    end
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b1000) begin
      tests_failed++; $display("FAIL drop_next: gnt=%b required 1000", gnt);
    end
    tick();
    full = 1'b1; req = 4'b0000;
    #1;
    tests_run++;
    if (wr_en !== 1'b0) begin
      tests_failed++; $display("FAIL fulldrop_nowrite: wr_en=%b required 0", wr_en);
    end
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL fulldrop_idle: gnt=%b busy=%b required 0000 0", gnt, busy);
    end
    full = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    do_reset();
    req = 4'b1000;
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b1000) begin
      tests_failed++; $display("FAIL rstmid_grant: gnt=%b required 1000", gnt);
    end
    tick();
    rst = 1'b1; req = 4'b1111;
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rstmid_abort: gnt=%b wr_en=%b busy=%b ack=%b required 0000 0 0 0000",
               gnt, wr_en, busy, ack);
    end
    rst = 1'b0;
    tick();
    #1;
    tests_run++;
    if (gnt !== 4'b0001) begin
      tests_failed++; $display("FAIL rstmid_regrant: gnt=%b required 0001", gnt);
    end
    req = '0;
    tick(); tick();
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    int n;
    do_reset();
    req = 4'b0001;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      #1;
      if (wr_en === 1'b1) n++;
      if (n == 10) req = '0;
      tick();
    end
    req = '0;
    #1;
    tests_run++;
    if (wr_count !== 16'd10) begin
      tests_failed++; $display("FAIL stats_count: wr_count=%0d required 10", wr_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (wr_count !== 16'd0) begin
      tests_failed++; $display("FAIL stats_reset: wr_count=%0d required 0", wr_count);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      end
      full     = ($urandom_range(0, 3) == 0);
      req_data = $urandom;
      rst      = ($urandom_range(0, 99) == 0);
      #1;
      tests_run++;
      if (gnt !== exp_gnt() || wr_en !== exp_wr_en() || busy !== m_busy ||
          ack !== (exp_wr_en() ? exp_gnt() : 4'b0000) || data_in !== exp_data()) begin
        tests_failed++;
        $display("FAIL random_c%0d: gnt=%b wr_en=%b ack=%b data=%h busy=%b required %b %b %b %h %b",
                 c, gnt, wr_en, ack, data_in, busy, exp_gnt(), exp_wr_en(),
                 exp_wr_en() ? exp_gnt() : 4'b0000, exp_data(), m_busy);
      end
`ifdef FIFO_WR_ARB_STATS_EN
      tests_run++;
      if (wr_count !== m_wr_count) begin
        tests_failed++;
        $display("FAIL random_wrcount_c%0d: wr_count=%0d required %0d", c, wr_count, m_wr_count);
      end
`endif
      tick();
    end
    rst = 1'b0; req = '0; full = 1'b0;
    tick();
  endtask

  initial begin
    m_busy = 0; m_owner = 0; m_cnt = 0; m_last = N - 1; m_wr_count = 16'd0;
    rst = 1'b1; req = '0; full = 1'b0; req_data = '0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop();
    test_rst_mid();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DATA_W, default 8, FIFO data width.
REQ-003 Parameter MAX_BURST, default 4, max writes per grant (1..15).
REQ-004 wr_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  NUM_REQ  per-requester write request, level, held while data pending.
REQ-007 req_data  input  NUM_REQ*DATA_W  requester i data on bits [i*DATA_W +: DATA_W].
REQ-008 full  input  1  FIFO full flag, write-clock domain.
REQ-009 gnt  output  NUM_REQ  registered one-hot owner; all-zero when idle.
REQ-010 ack  output  NUM_REQ  one-hot; ack[i]=1 in the cycle requester i's word is written.
REQ-011 wr_en  output  1  FIFO write enable.
REQ-012 data_in  output  DATA_W  FIFO write data.
REQ-013 busy  output  1  high while in BURST state.

Function
REQ-014 States SHALL be IDLE and BURST, held in a registered state variable.
REQ-015 In IDLE with any req high, the arbiter SHALL pick the first set req[] scanning from (last_owner+1) mod NUM_REQ upward with wrap, load gnt one-hot and last_owner, clear burst_cnt, and enter BURST at the next edge (1-cycle req-to-gnt latency).
REQ-016 In IDLE with req all-zero, state, gnt and last_owner SHALL hold.
REQ-017 In BURST, wr_en SHALL equal req[owner] AND NOT full, combinationally from registered gnt.
REQ-018 ack SHALL equal gnt when wr_en=1, else all-zero.
REQ-019 data_in SHALL equal the owner's req_data slice when wr_en=1, else all-zero.
REQ-020 wr_en SHALL never assert while full=1 and never assert in IDLE.
REQ-021 Each write SHALL increment 4-bit burst_cnt; full=1 stalls with burst_cnt and owner held.
REQ-022 BURST SHALL return to IDLE at the next edge when req[owner]=0, or when a write brings burst_cnt to MAX_BURST.
REQ-023 After burst exit, the exiting owner SHALL have lowest priority in the following IDLE arbitration.
REQ-024 Requests from non-owners during BURST SHALL be ignored, not lost: they are serviced by later arbitration while still held.
REQ-025 Simultaneous full rising and owner req falling: no write, exit to IDLE.

Reset
REQ-026 With rst=1 at an edge: state=IDLE, gnt=0, burst_cnt=0, last_owner=NUM_REQ-1 (requester 0 first priority).
REQ-027 While in reset-state, wr_en=0, ack=0, data_in=0, busy=0.
REQ-028 rst mid-burst SHALL abort the burst at that edge with no further write; rst overrides all other inputs.

Configuration
REQ-029 Macro FIFO_WR_ARB_STATS_EN defined: extra output wr_count (16 bits) SHALL count total wr_en cycles, wrap at 16'hFFFF to 0, reset to 0.
REQ-030 Macro FIFO_WR_ARB_STATS_EN undefined: port wr_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset then req=4'b0001, data0=8'd3..8'd7 sequentially, full=0 -> gnt=0001 one cycle later, four writes 3,4,5,6 with ack=0001, then IDLE, regrant, write 7.
REQ-032 req=4'b1111 held, full=0 -> owners 0,1,2,3,0 in order, each exactly 4 writes, one idle bubble between bursts.
REQ-033 Owner 2 mid-burst, full=1 for 3 cycles -> wr_en=0, ack=0, gnt=0100 held, burst_cnt unchanged; resumes on full=0.
REQ-034 Owner 1 drops req after 2 writes while req[3]=1 -> IDLE next edge, then gnt=1000.
REQ-035 rst=1 during burst of owner 3 -> next cycle gnt=0, wr_en=0, busy=0; req=1111 then grants owner 0 first.
REQ-036 FIFO_WR_ARB_STATS_EN defined, 10 writes then rst -> wr_count=10, then 0.
